reset_sequencer: RTL

//  Parametrised successor to the per-domain two-flop reset synchroniser. Synchronises one

---
 rtl/reset_sequencer.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Purpose:
//   One instance per clock domain. Synchronises the combined reset condition
//   (external reset OR PLL not locked) into the clk domain through a
//   SYNC_STAGES-deep chain. It then holds reset for HOLD_CYCLES edges and
//   releases NUM_OUT active-low resets one at a time, index 0 first, with
//   STEP_CYCLES edges between releases. An optional synchronous software
//   request restarts the hold/release sequence without touching the
//   synchroniser.
//
// Configuration macro:
//   RESET_SEQ_SW_REQ_EN  defined     -> sw_rst_req is honoured
//                        not defined -> sw_rst_req is ignored (port kept)
//
// Parameters:
//   SYNC_STAGES  synchroniser depth (>=2)
//   NUM_OUT      number of sequenced reset outputs (>=1)
//   HOLD_CYCLES  edges reset stays asserted after sync_ok rises (>=1)
//   STEP_CYCLES  edges between successive output releases (>=1)
//
// Ports:
//   clk            in   1        clock
//   rst_condition  in   1        asynchronous, active-high reset condition
//   sw_rst_req     in   1        synchronous software reset request (level)
//   rst_n_out      out  NUM_OUT  sequenced resets, active-low,
//                                async assert / sync release
//   rst_done       out  1        high once every rst_n_out bit is released
//   seq_state      out  2        FSM state: 0 ASSERT, 1 HOLD, 2 RELEASE, 3 RUN
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_OUT     = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STEP_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst_condition,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] rst_n_out,
  output logic               rst_done,
  output logic [1:0]         seq_state
);

  localparam int CNT_MAX = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [IW-1:0] IDX_ZERO  = IW'(0);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_ok_s;
  logic                   sync_pre_s;
  logic                   sw_req_s;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [CW-1:0]          cnt_r;
  logic [CW-1:0]          cnt_nxt_s;
  logic [IW-1:0]          idx_r;
  logic [IW-1:0]          idx_nxt_s;
  logic [NUM_OUT-1:0]     rst_n_r;
  logic [NUM_OUT-1:0]     rst_n_nxt_s;
  logic                   done_r;
  logic                   done_nxt_s;
  logic [NUM_OUT-1:0]     release_mask_s;

`ifdef RESET_SEQ_SW_REQ_EN
  assign sw_req_s = sw_rst_req;
`else
  // Port is kept for a uniform interface; the request has no effect.
  logic unused_sw_rst_req;
  assign unused_sw_rst_req = sw_rst_req;
  assign sw_req_s          = 1'b0;
`endif

  // Reset synchroniser: shifts in ones once rst_condition is low.
  always_ff @(posedge clk or posedge rst_condition) begin
    if (rst_condition) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_ok_s  = sync_r[SYNC_STAGES-1];
  // The stage before sync_ok tells us sync_ok rises on this edge. Entering
  // HOLD on that same edge makes the hold window count HOLD_CYCLES edges
  // from the rise of sync_ok, the same as a software restart does.
  assign sync_pre_s = sync_r[SYNC_STAGES-2];

  // One-hot mask for the output bit that the current idx would release.
  always_comb begin
    release_mask_s = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      release_mask_s[k] = (idx_r == IW'(k));
    end
  end

  // Sequencer state and output registers; rst_condition clears everything.
  always_ff @(posedge clk or posedge rst_condition) begin
    if (rst_condition) begin
      state_r <= ST_ASSERT;
      cnt_r   <= CNT_ZERO;
      idx_r   <= IDX_ZERO;
      rst_n_r <= '0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      rst_n_r <= rst_n_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Next-state, counter, index and output computation.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    rst_n_nxt_s = rst_n_r;
    done_nxt_s  = done_r;

    case (state_r)
      ST_ASSERT: begin
        rst_n_nxt_s = '0;
        done_nxt_s  = 1'b0;
        cnt_nxt_s   = CNT_ZERO;
        idx_nxt_s   = IDX_ZERO;
        if (sync_pre_s) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_ASSERT;
        end
      end

      ST_HOLD: begin
        if (sw_req_s) begin
          // A held request pins the counter at zero.
          state_nxt_s = ST_HOLD;
          cnt_nxt_s   = CNT_ZERO;
          idx_nxt_s   = IDX_ZERO;
          rst_n_nxt_s = '0;
          done_nxt_s  = 1'b0;
        end else if (!sync_ok_s) begin
          // Only possible on the entry edge; wait for the synchroniser.
          cnt_nxt_s = cnt_r;
        end else if (cnt_r == HOLD_LAST) begin
          rst_n_nxt_s[0] = 1'b1;
          cnt_nxt_s      = CNT_ZERO;
          if (NUM_OUT == 1) begin
            state_nxt_s = ST_RUN;
            done_nxt_s  = 1'b1;
            idx_nxt_s   = IDX_ZERO;
          end else begin
            state_nxt_s = ST_RELEASE;
            idx_nxt_s   = IDX_ONE;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end

      ST_RELEASE: begin
        if (sw_req_s) begin
          state_nxt_s = ST_HOLD;
          cnt_nxt_s   = CNT_ZERO;
          idx_nxt_s   = IDX_ZERO;
          rst_n_nxt_s = '0;
          done_nxt_s  = 1'b0;
        end else if (!sync_ok_s) begin
          cnt_nxt_s = cnt_r;
        end else if (cnt_r == STEP_LAST) begin
          rst_n_nxt_s = rst_n_r | release_mask_s;
          cnt_nxt_s   = CNT_ZERO;
          if (idx_r == IDX_LAST) begin
            state_nxt_s = ST_RUN;
            done_nxt_s  = 1'b1;
            idx_nxt_s   = IDX_ZERO;
          end else begin
            idx_nxt_s = idx_r + IDX_ONE;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end

      ST_RUN: begin
        if (sw_req_s) begin
          state_nxt_s = ST_HOLD;
          cnt_nxt_s   = CNT_ZERO;
          idx_nxt_s   = IDX_ZERO;
          rst_n_nxt_s = '0;
          done_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end

      default: begin
        state_nxt_s = ST_ASSERT;
        cnt_nxt_s   = CNT_ZERO;
        idx_nxt_s   = IDX_ZERO;
        rst_n_nxt_s = '0;
        done_nxt_s  = 1'b0;
      end
    endcase
  end

  assign rst_n_out = rst_n_r;
  assign rst_done  = done_r;
  assign seq_state = state_r;

endmodule
